ball_speed_ctrl: RTL and testbench
==================================

# ball_speed_ctrl

Speed scheduler for the ball refresh-rate divider. Tracks the game's speed level (raised by paddle hits, cleared by points) and drives the 22-bit divisor `N` into the ball refresh-rate divider. Changes `N` only at points where the divider cannot overshoot its compare value. Sequences serve hold-off and run phases, gating ball motion via `ball_enable`.

## Interface
- `N_START`, 22'd2_500_000: divisor at level 0 (ball tick = 50 MHz / N)
- `N_STEP`, 22'd200_000: divisor decrement per level
- `N_MIN`, 22'd500_000: divisor floor
- `MAX_LEVEL`, 10: saturating level limit (≤ 15)
- `SERVE_TICKS`, 40: ball-clock rising edges held in SERVE

- `clk_50MHz` input 1: system clock; all logic on rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `game_run` input 1: level; high = game active
- `paddle_hit` input 1: one-cycle pulse per paddle contact
- `point_scored` input 1: one-cycle pulse per point
- `boost` input 1: level; speed boost request (present only with macro)
- `ball_clk` input 1: divided clock from the refresh-rate divider, synchronous to `clk_50MHz`
- `N` output 22: divisor to the refresh-rate divider
- `speed_level` output 4: current level
- `ball_enable` output 1: high only in RUN
- `serve_hold` output 1: high only in SERVE

## Operation
- States: IDLE, SERVE, RUN.
  - IDLE: level 0; leaves to SERVE when `game_run`=1.
  - SERVE: counts rising edges of `ball_clk`; after `SERVE_TICKS` edges, goes to RUN.
  - RUN: `paddle_hit` raises level by 1, saturating at `MAX_LEVEL`; `point_scored` clears level to 0 and enters SERVE with the count cleared.
  - `game_run`=0 forces IDLE from any state and clears level.
- `paddle_hit` is ignored outside RUN.
- If `paddle_hit` and `point_scored` arrive in the same cycle, `point_scored` wins.
- Target divisor: `N_tgt = max(N_START − level·N_STEP, N_MIN)`.
  - Product computed at 26 bits; any underflow clamps to `N_MIN`.
- Safe update rule:
  - Registered `ball_clk_d`; a toggle is `ball_clk ^ ball_clk_d`.
  - At a toggle the divider's counter restarts at 1.
  - If `N_tgt > N`: `N` loads `N_tgt` next cycle.
  - If `N_tgt < N`: load is deferred until the first cycle with a detected toggle, then `N` loads `N_tgt`.
  - The pending target is always the latest one; intermediate levels are never applied.
- Reset values: `N`=`N_START`, `speed_level`=0, `ball_enable`=0, `serve_hold`=0, state IDLE, `ball_clk_d`=0, serve count 0.
- Reset asserted mid-game: immediate return to reset values; no pending update survives.

## Timing
- `speed_level` updates the cycle after the `paddle_hit` / `point_scored` pulse.
- `N_tgt` is registered one cycle after the level update.
- `N` changes 1 cycle after `N_tgt` (increase), or on the cycle after the next `ball_clk` toggle (decrease).
- State outputs are registered; `ball_enable` / `serve_hold` follow the state with 1-cycle latency.
- SERVE→RUN occurs on the cycle after the `SERVE_TICKS`-th rising edge is detected.

## Configuration
- `BALL_SPEED_BOOST_EN` defined:
  - `boost` port exists.
  - In RUN with `boost`=1, `N_tgt = max(N_base>>1, N_MIN)`, where `N_base` is the level-based target.
  - The same safe-update rule applies to boost on/off transitions.
- Undefined: no `boost` port; `N_tgt` = level-based target only.

## Structure
- Shared package holds:
  - `DIV_W`=22 and `LEVEL_W`=4
  - state enum (IDLE/SERVE/RUN)
  - default divisor constants
- Sub-module `ball_div_target`: combinational level(+boost) → clamped `N_tgt`. All sequencing stays in the top.

## Test plan
- Reset, `game_run`=1, then 40 `ball_clk` rising edges → `serve_hold` drops, `ball_enable`=1, `N`=2_500_000.
- 3 `paddle_hit` pulses in RUN → `speed_level`=3; `N` stays 2_500_000 until the next `ball_clk` toggle, then becomes 1_900_000.
- 12 hits → `speed_level` saturates at 10; `N`=500_000; an 11th hit changes nothing.
- `paddle_hit` and `point_scored` in the same cycle at level 5 → level 0, SERVE; `N` loads 2_500_000 one cycle after `N_tgt` (increase, no wait).
- `rst_n` pulsed low mid-RUN at level 7 → all outputs at reset values asynchronously; pending decrease discarded.
- With `BALL_SPEED_BOOST_EN`, level 0, `boost`=1 → `N` becomes 1_250_000 at the next toggle; `boost`=0 → 2_500_000 one cycle after `N_tgt` (increase, no wait).

Source files
------------

// File: rtl/ball_speed_ctrl_pkg.sv
// Shared types and constants for the ball speed scheduler.
// Widths, divisor limits, level limit and the sequencer state enum.
package ball_speed_ctrl_pkg;

  localparam int DIV_W   = 22;
  localparam int LEVEL_W = 4;
  localparam int PROD_W  = 26;
  localparam int CNT_W   = 6;

  localparam logic [DIV_W-1:0] N_START = 22'd2_500_000;
  localparam logic [DIV_W-1:0] N_STEP  = 22'd200_000;
  localparam logic [DIV_W-1:0] N_MIN   = 22'd500_000;

  localparam logic [LEVEL_W-1:0] MAX_LEVEL = 4'd10;

  localparam int SERVE_TICKS = 40;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    RUN   = 2'd2
  } state_t;

  function automatic logic [DIV_W-1:0] clamp_min(
    input logic [DIV_W-1:0] v
  );
    return (v < N_MIN) ? N_MIN : v;
  endfunction

endpackage

// File: rtl/ball_speed_ctrl_div_target.sv
// Combinational level(+boost) to clamped divisor target.
// Ports: level in, boost in (BALL_SPEED_BOOST_EN only), n_tgt out.
module ball_div_target
  import ball_speed_ctrl_pkg::*;
(
  input  logic [LEVEL_W-1:0] level,
`ifdef BALL_SPEED_BOOST_EN
  input  logic               boost,
`endif
  output logic [DIV_W-1:0]   n_tgt
);

  logic [PROD_W-1:0] prod;
  logic [DIV_W-1:0]  diff;
  logic [DIV_W-1:0]  base;

  always_comb begin
    prod = PROD_W'(level) * PROD_W'(N_STEP);
    diff = '0;
    base = N_MIN;
    // prod below N_START means the low bits hold it exactly
    if (prod < PROD_W'(N_START)) begin
      diff = N_START - prod[DIV_W-1:0];
      base = clamp_min(diff);
    end
  end

`ifdef BALL_SPEED_BOOST_EN
  always_comb begin
    n_tgt = base;
    if (boost) n_tgt = clamp_min(base >> 1);
  end
`else
  assign n_tgt = base;
`endif

endmodule

// File: rtl/ball_speed_ctrl.sv
// Ball speed scheduler: level tracking, serve sequencing, safe N updates.
// Ports: clk_50MHz, rst_n, game_run, paddle_hit, point_scored, boost
// (BALL_SPEED_BOOST_EN only), ball_clk -> N, speed_level, ball_enable,
// serve_hold.
module ball_speed_ctrl
  import ball_speed_ctrl_pkg::*;
(
  input  logic               clk_50MHz,
  input  logic               rst_n,
  input  logic               game_run,
  input  logic               paddle_hit,
  input  logic               point_scored,
`ifdef BALL_SPEED_BOOST_EN
  input  logic               boost,
`endif
  input  logic               ball_clk,
  output logic [DIV_W-1:0]   N,
  output logic [LEVEL_W-1:0] speed_level,
  output logic               ball_enable,
  output logic               serve_hold
);

  state_t             state;
  state_t             state_nx;
  logic [CNT_W-1:0]   serve_cnt;
  logic [CNT_W-1:0]   serve_cnt_nx;
  logic [LEVEL_W-1:0] level_nx;
  logic               ball_clk_d;
  logic               toggle;
  logic               rise;
  logic [DIV_W-1:0]   n_tgt_c;
  logic [DIV_W-1:0]   n_tgt_q;

  assign toggle = ball_clk ^ ball_clk_d;
  assign rise   = ball_clk & ~ball_clk_d;

`ifdef BALL_SPEED_BOOST_EN
  logic boost_run;
  assign boost_run = boost & (state == RUN);

  ball_div_target u_tgt (
    .level (speed_level),
    .boost (boost_run),
    .n_tgt (n_tgt_c)
  );
`else
  ball_div_target u_tgt (
    .level (speed_level),
    .n_tgt (n_tgt_c)
  );
`endif

  always_comb begin
    state_nx     = state;
    serve_cnt_nx = serve_cnt;
    level_nx     = speed_level;
    if (!game_run) begin
      state_nx     = IDLE;
      serve_cnt_nx = '0;
      level_nx     = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_nx     = SERVE;
          serve_cnt_nx = '0;
          level_nx     = '0;
        end
        SERVE: begin
          if (rise) begin
            if (serve_cnt == CNT_W'(SERVE_TICKS - 1)) begin
              state_nx     = RUN;
              serve_cnt_nx = '0;
            end else begin
              serve_cnt_nx = serve_cnt + 1'b1;
            end
          end
        end
        RUN: begin
          // a point in the same cycle as a hit takes precedence
          priority case (1'b1)
            point_scored: begin
              level_nx     = '0;
              state_nx     = SERVE;
              serve_cnt_nx = '0;
            end
            paddle_hit && (speed_level < MAX_LEVEL): begin
              level_nx = speed_level + 1'b1;
            end
            default: ;
          endcase
        end
        default: begin
          state_nx     = IDLE;
          serve_cnt_nx = '0;
          level_nx     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      serve_cnt   <= '0;
      speed_level <= '0;
      ball_clk_d  <= 1'b0;
      ball_enable <= 1'b0;
      serve_hold  <= 1'b0;
    end else begin
      state       <= state_nx;
      serve_cnt   <= serve_cnt_nx;
      speed_level <= level_nx;
      ball_clk_d  <= ball_clk;
      ball_enable <= (state == RUN);
      serve_hold  <= (state == SERVE);
    end
  end

  // A larger N can never be overshot, so it loads at once. A smaller
  // N is held back until the divider restarts its count on a toggle.
  // Comparing the live target each cycle keeps only the latest one.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      n_tgt_q <= N_START;
      N       <= N_START;
    end else begin
      n_tgt_q <= n_tgt_c;
      if (n_tgt_q > N) begin
        N <= n_tgt_q;
      end else if ((n_tgt_q < N) && toggle) begin
        N <= n_tgt_q;
      end
    end
  end

endmodule

// File: tb/tb_ball_speed_ctrl.sv
// Self-checking bench for ball_speed_ctrl: cycle model + directed checks.
// Boost scenario runs only when BALL_SPEED_BOOST_EN is defined.
module tb_ball_speed_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        game_run = 1'b0;
  logic        paddle_hit = 1'b0;
  logic        point_scored = 1'b0;
  logic        ball_clk = 1'b0;
  logic [21:0] n_o;
  logic [3:0]  lvl_o;
  logic        en_o;
  logic        hold_o;
`ifdef BALL_SPEED_BOOST_EN
  logic        boost = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  always #10 clk = ~clk;

  ball_speed_ctrl dut (
    .clk_50MHz    (clk),
    .rst_n        (rst_n),
    .game_run     (game_run),
    .paddle_hit   (paddle_hit),
    .point_scored (point_scored),
`ifdef BALL_SPEED_BOOST_EN
    .boost        (boost),
`endif
    .ball_clk     (ball_clk),
    .N            (n_o),
    .speed_level  (lvl_o),
    .ball_enable  (en_o),
    .serve_hold   (hold_o)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model: phase 0=idle 1=serve 2=run
  int m_ph, m_cnt, m_lvl, m_tgt, m_n;
  bit m_bcd, m_en, m_hold;

  function automatic int tgt_of(input int lvl, input bit b);
    int v;
    v = 2500000 - lvl * 200000;
    if (v < 500000) v = 500000;
    if (b) begin
      v = v / 2;
      if (v < 500000) v = 500000;
    end
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit tog, rise, bst;
    if (!rst_n) begin
      m_ph = 0; m_cnt = 0; m_lvl = 0; m_bcd = 0;
      m_tgt = 2500000; m_n = 2500000; m_en = 0; m_hold = 0;
    end else begin
      bst = 1'b0;
`ifdef BALL_SPEED_BOOST_EN
      bst = boost && (m_ph == 2);
`endif
      tog  = (ball_clk != m_bcd);
      rise = ball_clk && !m_bcd;
      if (m_tgt > m_n) m_n = m_tgt;
      else if (m_tgt < m_n && tog) m_n = m_tgt;
      m_tgt  = tgt_of(m_lvl, bst);
      m_en   = (m_ph == 2);
      m_hold = (m_ph == 1);
      if (!game_run) begin
        m_ph = 0; m_cnt = 0; m_lvl = 0;
      end else if (m_ph == 0) begin
        m_ph = 1; m_cnt = 0;
      end else if (m_ph == 1) begin
        if (rise) m_cnt++;
        if (m_cnt == 40) begin m_ph = 2; m_cnt = 0; end
      end else begin
        if (point_scored) begin
          m_lvl = 0; m_ph = 1; m_cnt = 0;
        end else if (paddle_hit && m_lvl < 10) begin
          m_lvl++;
        end
      end
      m_bcd = ball_clk;
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (rst_n && chk_en) begin
      check("N", int'(n_o), m_n);
      check("level", int'(lvl_o), m_lvl);
      check("ball_enable", int'(en_o), int'(m_en));
      check("serve_hold", int'(hold_o), int'(m_hold));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tgl();
    @(negedge clk);
    ball_clk = ~ball_clk;
    @(negedge clk);
  endtask

  task automatic hit(input int n);
    repeat (n) begin
      @(negedge clk); paddle_hit = 1'b1;
      @(negedge clk); paddle_hit = 1'b0;
    end
  endtask

  task automatic point();
    @(negedge clk); point_scored = 1'b1;
    @(negedge clk); point_scored = 1'b0;
  endtask

  task automatic serve();
    int r;
    r = 0;
    while (r < 40) begin
      tgl();
      if (ball_clk) r++;
    end
    cyc(3);
  endtask

  initial begin
    cyc(3);
    check("rst_N", int'(n_o), 2500000);
    check("rst_level", int'(lvl_o), 0);
    check("rst_en", int'(en_o), 0);
    check("rst_hold", int'(hold_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    cyc(2);
    game_run = 1'b1;
    cyc(3);
    check("serve_hold_on", int'(hold_o), 1);
    serve();
    check("run_en", int'(en_o), 1);
    check("run_hold", int'(hold_o), 0);
    check("run_N", int'(n_o), 2500000);

    hit(3);
    cyc(4);
    check("lvl3", int'(lvl_o), 3);
    check("lvl3_N_held", int'(n_o), 2500000);
    tgl();
    check("lvl3_N", int'(n_o), 1900000);

    hit(9);
    cyc(3);
    check("lvl_sat", int'(lvl_o), 10);
    tgl();
    check("sat_N", int'(n_o), 500000);
    hit(1);
    cyc(3);
    check("sat_hit_lvl", int'(lvl_o), 10);
    check("sat_hit_N", int'(n_o), 500000);

    point();
    cyc(3);
    serve();
    hit(5);
    cyc(3);
    tgl();
    check("lvl5_N", int'(n_o), 1500000);
    @(negedge clk);
    paddle_hit = 1'b1; point_scored = 1'b1;
    @(negedge clk);
    paddle_hit = 1'b0; point_scored = 1'b0;
    check("both_lvl", int'(lvl_o), 0);
    @(negedge clk);
    check("both_N_pre", int'(n_o), 1500000);
    check("both_hold", int'(hold_o), 1);
    @(negedge clk);
    check("both_N", int'(n_o), 2500000);

    cyc(2);
    serve();
    hit(7);
    cyc(3);
    check("lvl7", int'(lvl_o), 7);
    check("lvl7_N_pend", int'(n_o), 2500000);
    #3 rst_n = 1'b0;
    #1;
    check("arst_N", int'(n_o), 2500000);
    check("arst_lvl", int'(lvl_o), 0);
    check("arst_en", int'(en_o), 0);
    check("arst_hold", int'(hold_o), 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    tgl();
    tgl();
    check("post_rst_N", int'(n_o), 2500000);

`ifdef BALL_SPEED_BOOST_EN
    serve();
    boost = 1'b1;
    cyc(3);
    check("boost_N_held", int'(n_o), 2500000);
    tgl();
    check("boost_N", int'(n_o), 1250000);
    boost = 1'b0;
    @(negedge clk);
    check("unboost_N_pre", int'(n_o), 1250000);
    @(negedge clk);
    check("unboost_N", int'(n_o), 2500000);
`endif

    cyc(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
